nts_dispatcher_multibuf: RTL and testbench
==========================================

Name: nts_dispatcher_multibuf

Overview:
Parametrised successor to the two-buffer dispatcher. It sits between the MAC RX stream and the dispatcher backend, and captures each incoming frame into one of 2^BUF_LOG2 BRAM buffers arranged as a ring. Frames are handed to the backend in arrival order. Frames are dropped when they are bad, rejected by the pre-processor, too long, or arrive with no free buffer. Drop statistics are optional.

Parameters:
ADDR_WIDTH, 8, word address width per buffer; each buffer holds 2^ADDR_WIDTH 64-bit words.
BUF_LOG2, 2, log2 of the buffer count; 4 buffers by default; legal range 1..4.

Ports:
i_clk  in  1  clock
i_areset  in  1  reset, synchronous, active-high
i_rx_data_valid  in  8  byte mask of i_rx_data; 0 = no word this cycle
i_rx_data  in  64  RX word
i_rx_bad_frame  in  1  current frame is bad; pulse
i_rx_good_frame  in  1  current frame is good; pulse, coincides with the last word
i_process_frame  in  1  pre-processor accepts the current frame; pulse
o_dispatch_packet_available  out  1  the head buffer is READY
i_dispatch_packet_read_discard  in  1  free the head buffer; pulse
o_dispatch_counter  out  ADDR_WIDTH  index of the last word in the head buffer
o_dispatch_data_valid  out  8  byte mask of the last word in the head buffer
o_dispatch_fifo_empty  out  1  no unread words remain in the head buffer
i_dispatch_fifo_rd_en  in  1  read the next word
o_dispatch_fifo_rd_data  out  64  read word; valid 1 cycle after rd_en
o_stat_drop_full  out  32  frames dropped because no buffer was free
o_stat_drop_overrun  out  32  frames dropped for exceeding buffer depth
o_stat_drop_reject  out  32  frames dropped as bad, malformed or not accepted

Behaviour:
- One clock, i_clk. i_areset is synchronous and active-high.
- Reset values:
  - every buffer FREE; write pointer wp = 0; read pointer rp = 0; read address = 0;
  - all outputs 0, except o_dispatch_fifo_empty = 1;
  - stat counters 0.
- Reset asserted mid-frame or mid-read: the frame in progress and all READY buffers are lost.
- Buffer states: FREE, FILLING, READY.
- Write FSM states: IDLE, RECV, DROP.
- IDLE, first word arrives (data_valid != 0):
  - if buffer[wp] is FREE: write the word to address 0, set counter = 0, clear the process flag, mark buffer[wp] FILLING, go to RECV;
  - otherwise: go to DROP and increment drop_full.
- RECV: every word is written to counter+1, and counter increments.
  - A word arriving while counter is all-ones: the frame is discarded and drop_overrun increments.
  - A non-zero mask other than 0xFF on a word without good_frame makes the frame malformed: it is discarded and drop_reject increments.
- i_process_frame seen while RECV, including on the good_frame cycle, sets the process flag.
- good_frame in RECV:
  - the last word is written and its mask captured into data_valid;
  - if the process flag is set: buffer[wp] becomes READY, wp increments modulo 2^BUF_LOG2, go to IDLE;
  - otherwise: discard, drop_reject increments.
- Discard always returns buffer[wp] to FREE and goes to IDLE, except that a frame whose last word has not yet arrived goes to DROP and reaches IDLE on good_frame or bad_frame.
- bad_frame in RECV: discard, drop_reject increments.
- bad_frame and good_frame together count as bad.
- DROP: ignore all input until good_frame or bad_frame, then go to IDLE. No further counter increments.
- A good_frame or bad_frame arriving in IDLE is ignored.
- Read side:
  - the head buffer is rp; o_dispatch_packet_available = (buffer[rp] == READY);
  - fifo_empty is cleared on the cycle the head becomes READY;
  - rd_en while not empty presents the current read address; data appears on rd_data the next cycle; the address increments;
  - the rd_en that reads index == counter also sets fifo_empty;
  - rd_en while empty is ignored.
- read_discard while available:
  - buffer[rp] becomes FREE, rp increments, read address resets to 0, fifo_empty = 1;
  - if the next buffer is already READY, empty clears on the following cycle.
- read_discard while not available is ignored.
- Simultaneous write-commit and read-discard of different buffers are both honoured in the same cycle.
- A buffer freed by discard may be claimed by a frame starting on the next cycle.
- Stat counters saturate at 0xFFFFFFFF.
- Latency from good_frame (with the process flag set) to available is 1 cycle.

Optional Feature:
NTS_DISPATCHER_STATS_EN
- Defined: the three 32-bit saturating counters are implemented as described.
- Undefined: the counter logic is not built, and the three o_stat_* ports are constant 0.
- All other behaviour is identical either way.

Test Plan:
- 3-word frame (masks FF, FF, 0F; process pulsed on word 2; good_frame on word 3) -> available after 1 cycle; counter = 2; data_valid = 0x0F; three rd_en cycles return the three words in order; empty = 1 after the third.
- 5 accepted frames with no reads, BUF_LOG2 = 2 -> frames 1-4 READY; frame 5 dropped; drop_full = 1; after one discard, frame 6 is accepted into buffer 0.
- Frame of 2^ADDR_WIDTH + 1 words -> discarded; drop_overrun = 1; buffer remains FREE; the following good frame is captured normally.
- Frame with bad_frame on word 2, then a frame whose good_frame arrives without any process pulse -> both discarded; drop_reject = 2; available stays 0.
- Discard of buffer 0 on the same cycle buffer 1 commits -> rp = 1; available = 1 with empty clearing one cycle later; buffer 1 data read back intact.
- Reset asserted during RECV with 2 READY buffers -> next cycle: available = 0, empty = 1, all stats 0, and a new frame is written to buffer 0.

Source files
------------

// File: rtl/nts_dispatcher_multibuf.sv
// Multi-buffer RX frame dispatcher: captures MAC frames into a ring of BRAM buffers
// and hands them to the backend in arrival order. Drop statistics under NTS_DISPATCHER_STATS_EN.
module nts_dispatcher_multibuf #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BUF_LOG2   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic [7:0]            i_rx_data_valid,
  input  logic [63:0]           i_rx_data,
  input  logic                  i_rx_bad_frame,
  input  logic                  i_rx_good_frame,
  input  logic                  i_process_frame,
  output logic                  o_dispatch_packet_available,
  input  logic                  i_dispatch_packet_read_discard,
  output logic [ADDR_WIDTH-1:0] o_dispatch_counter,
  output logic [7:0]            o_dispatch_data_valid,
  output logic                  o_dispatch_fifo_empty,
  input  logic                  i_dispatch_fifo_rd_en,
  output logic [63:0]           o_dispatch_fifo_rd_data,
  output logic [31:0]           o_stat_drop_full,
  output logic [31:0]           o_stat_drop_overrun,
  output logic [31:0]           o_stat_drop_reject
);

  localparam int unsigned NBUF  = 1 << BUF_LOG2;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned MW    = BUF_LOG2 + ADDR_WIDTH;

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wstate_t;
  typedef enum logic [1:0] {B_FREE, B_FILLING, B_READY} bstate_t;

  wstate_t               wst_q, wst_d;
  bstate_t               bst_q [NBUF];
  bstate_t               bst_d [NBUF];
  logic [ADDR_WIDTH-1:0] cnt_q [NBUF];
  logic [ADDR_WIDTH-1:0] cnt_d [NBUF];
  logic [7:0]            dv_q  [NBUF];
  logic [7:0]            dv_d  [NBUF];
  logic [BUF_LOG2-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d, ra_q, ra_d;
  logic                  proc_q, proc_d;
  logic                  empty_q, empty_d;
  logic                  loaded_q, loaded_d;
  logic [63:0]           rd_data_q;
  logic [63:0]           mem [NBUF*DEPTH];

  logic                  word_c, avail_c, commit_c, rd_en_c, mem_we_c;
  logic [MW-1:0]         mem_waddr_c;
  logic                  inc_full_c, inc_overrun_c, inc_reject_c;

  // Write FSM and read-side bookkeeping share one block since both update buffer states.
  always_comb begin
    wst_d         = wst_q;
    bst_d         = bst_q;
    cnt_d         = cnt_q;
    dv_d          = dv_q;
    wp_d          = wp_q;
    rp_d          = rp_q;
    wcnt_d        = wcnt_q;
    ra_d          = ra_q;
    proc_d        = proc_q;
    empty_d       = empty_q;
    loaded_d      = loaded_q;
    commit_c      = 1'b0;
    rd_en_c       = 1'b0;
    mem_we_c      = 1'b0;
    mem_waddr_c   = {wp_q, wcnt_q + ADDR_WIDTH'(1)};
    inc_full_c    = 1'b0;
    inc_overrun_c = 1'b0;
    inc_reject_c  = 1'b0;
    word_c        = |i_rx_data_valid;
    avail_c       = (bst_q[rp_q] == B_READY);

    case (wst_q)
      W_IDLE: begin
        if (word_c) begin
          if (bst_q[wp_q] == B_FREE) begin
            mem_we_c     = 1'b1;
            mem_waddr_c  = {wp_q, ADDR_WIDTH'(0)};
            wcnt_d       = '0;
            proc_d       = 1'b0;
            bst_d[wp_q]  = B_FILLING;
            wst_d        = W_RECV;
          end else begin
            inc_full_c = 1'b1;
            wst_d      = W_DROP;
          end
        end
      end
      W_RECV: begin
        if (i_process_frame) proc_d = 1'b1;
        if (i_rx_bad_frame) begin
          inc_reject_c = 1'b1;
          bst_d[wp_q]  = B_FREE;
          wst_d        = W_IDLE;
        end else if (word_c) begin
          if (&wcnt_q) begin
            inc_overrun_c = 1'b1;
            bst_d[wp_q]   = B_FREE;
            wst_d         = i_rx_good_frame ? W_IDLE : W_DROP;
          end else if (i_rx_good_frame) begin
            mem_we_c = 1'b1;
            wst_d    = W_IDLE;
            if (proc_q || i_process_frame) begin
              commit_c    = 1'b1;
              cnt_d[wp_q] = wcnt_q + ADDR_WIDTH'(1);
              dv_d[wp_q]  = i_rx_data_valid;
              bst_d[wp_q] = B_READY;
              wp_d        = wp_q + BUF_LOG2'(1);
            end else begin
              inc_reject_c = 1'b1;
              bst_d[wp_q]  = B_FREE;
            end
          end else if (i_rx_data_valid != 8'hFF) begin
            inc_reject_c = 1'b1;
            bst_d[wp_q]  = B_FREE;
            wst_d        = W_DROP;
          end else begin
            mem_we_c = 1'b1;
            wcnt_d   = wcnt_q + ADDR_WIDTH'(1);
          end
        end else if (i_rx_good_frame) begin
          // Good end without a final word is treated as malformed.
          inc_reject_c = 1'b1;
          bst_d[wp_q]  = B_FREE;
          wst_d        = W_IDLE;
        end
      end
      W_DROP: begin
        if (i_rx_good_frame || i_rx_bad_frame) wst_d = W_IDLE;
      end
      default: wst_d = W_IDLE;
    endcase

    // loaded_q marks that the current head has already been opened for reading.
    if (i_dispatch_packet_read_discard && avail_c) begin
      bst_d[rp_q] = B_FREE;
      rp_d        = rp_q + BUF_LOG2'(1);
      ra_d        = '0;
      empty_d     = 1'b1;
      loaded_d    = 1'b0;
    end else if (i_dispatch_fifo_rd_en && !empty_q) begin
      rd_en_c = 1'b1;
      ra_d    = ra_q + ADDR_WIDTH'(1);
      if (ra_q == cnt_q[rp_q]) empty_d = 1'b1;
    end else if (!loaded_q && (avail_c || (commit_c && (wp_q == rp_q)))) begin
      empty_d  = 1'b0;
      loaded_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      wst_q    <= W_IDLE;
      bst_q    <= '{default: B_FREE};
      cnt_q    <= '{default: '0};
      dv_q     <= '{default: '0};
      wp_q     <= '0;
      rp_q     <= '0;
      wcnt_q   <= '0;
      ra_q     <= '0;
      proc_q   <= 1'b0;
      empty_q  <= 1'b1;
      loaded_q <= 1'b0;
    end else begin
      wst_q    <= wst_d;
      bst_q    <= bst_d;
      cnt_q    <= cnt_d;
      dv_q     <= dv_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      wcnt_q   <= wcnt_d;
      ra_q     <= ra_d;
      proc_q   <= proc_d;
      empty_q  <= empty_d;
      loaded_q <= loaded_d;
    end
  end

  // Buffer storage, one flat BRAM indexed by {buffer, word}.
  always_ff @(posedge i_clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_areset)     rd_data_q <= '0;
    else if (rd_en_c) rd_data_q <= mem[{rp_q, ra_q}];
  end

  assign o_dispatch_packet_available = avail_c;
  assign o_dispatch_counter          = cnt_q[rp_q];
  assign o_dispatch_data_valid       = dv_q[rp_q];
  assign o_dispatch_fifo_empty       = empty_q;
  assign o_dispatch_fifo_rd_data     = rd_data_q;

`ifdef NTS_DISPATCHER_STATS_EN
  logic [31:0] st_full_q, st_full_d, st_over_q, st_over_d, st_rej_q, st_rej_d;

  // Saturating drop counters.
  always_comb begin
    st_full_d = st_full_q;
    st_over_d = st_over_q;
    st_rej_d  = st_rej_q;
    if (inc_full_c && !(&st_full_q))    st_full_d = st_full_q + 32'd1;
    if (inc_overrun_c && !(&st_over_q)) st_over_d = st_over_q + 32'd1;
    if (inc_reject_c && !(&st_rej_q))   st_rej_d  = st_rej_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      st_full_q <= '0;
      st_over_q <= '0;
      st_rej_q  <= '0;
    end else begin
      st_full_q <= st_full_d;
      st_over_q <= st_over_d;
      st_rej_q  <= st_rej_d;
    end
  end

  assign o_stat_drop_full    = st_full_q;
  assign o_stat_drop_overrun = st_over_q;
  assign o_stat_drop_reject  = st_rej_q;
`else
  logic unused_stats;
  assign unused_stats        = &{1'b0, inc_full_c, inc_overrun_c, inc_reject_c};
  assign o_stat_drop_full    = 32'd0;
  assign o_stat_drop_overrun = 32'd0;
  assign o_stat_drop_reject  = 32'd0;
`endif

endmodule

// File: tb/tb_nts_dispatcher_multibuf.sv
// Bench for nts_dispatcher_multibuf: directed scenarios plus random frames against a
// frame-queue reference model (ring occupancy = number of committed, unread frames).
module tb_nts_dispatcher_multibuf;
  localparam int unsigned AW    = 8;
  localparam int unsigned BL    = 2;
  localparam int          NBUF  = 4;
  localparam int          DEPTH = 256;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic [7:0]    rx_valid = '0;
  logic [63:0]   rx_data = '0;
  logic          rx_bad = 1'b0, rx_good = 1'b0, proc = 1'b0;
  logic          avail;
  logic          rd_discard = 1'b0;
  logic [AW-1:0] counter;
  logic [7:0]    dv;
  logic          empty;
  logic          rd_en = 1'b0;
  logic [63:0]   rd_data;
  logic [31:0]   st_full, st_over, st_rej;

  always #5 clk = ~clk;

  nts_dispatcher_multibuf #(.ADDR_WIDTH(AW), .BUF_LOG2(BL)) dut (
    .i_clk(clk), .i_areset(areset),
    .i_rx_data_valid(rx_valid), .i_rx_data(rx_data),
    .i_rx_bad_frame(rx_bad), .i_rx_good_frame(rx_good), .i_process_frame(proc),
    .o_dispatch_packet_available(avail),
    .i_dispatch_packet_read_discard(rd_discard),
    .o_dispatch_counter(counter), .o_dispatch_data_valid(dv),
    .o_dispatch_fifo_empty(empty), .i_dispatch_fifo_rd_en(rd_en),
    .o_dispatch_fifo_rd_data(rd_data),
    .o_stat_drop_full(st_full), .o_stat_drop_overrun(st_over), .o_stat_drop_reject(st_rej)
  );

  int n_checks = 0, n_pass = 0, n_fail = 0;
  // Reference model: committed frames in arrival order plus drop tallies.
  logic [63:0] mdata[$];
  int          mlen[$];
  logic [7:0]  mmask[$];
  int          m_full = 0, m_over = 0, m_rej = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_stats();
`ifdef NTS_DISPATCHER_STATS_EN
    check("drop_full", 64'(st_full), 64'(m_full));
    check("drop_overrun", 64'(st_over), 64'(m_over));
    check("drop_reject", 64'(st_rej), 64'(m_rej));
`else
    check("drop_full", 64'(st_full), 64'd0);
    check("drop_overrun", 64'(st_over), 64'd0);
    check("drop_reject", 64'(st_rej), 64'd0);
`endif
  endtask

  task automatic model_pop();
    int n;
    n = mlen.pop_front();
    void'(mmask.pop_front());
    for (int i = 0; i < n; i++) void'(mdata.pop_front());
  endtask

  // Drives one frame; the last word carries good (or bad). proc_at/malf_at < 0 disable them.
  task automatic send_frame(input int n, input logic [7:0] last_mask, input int proc_at,
                            input bit bad_end, input int malf_at, input bit disc_last);
    logic [63:0] fw[$];
    logic [63:0] w;
    bit space;
    space = (mlen.size() < NBUF);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w          = {$urandom, $urandom};
      rx_data    = w;
      rx_valid   = (i == n - 1) ? last_mask : ((i == malf_at) ? 8'h0F : 8'hFF);
      proc       = (i == proc_at);
      rx_good    = (i == n - 1) && !bad_end;
      rx_bad     = (i == n - 1) && bad_end;
      rd_discard = disc_last && (i == n - 1);
      fw.push_back(w);
    end
    @(negedge clk);
    rx_valid = '0; rx_good = 1'b0; rx_bad = 1'b0; proc = 1'b0; rd_discard = 1'b0;
    if (disc_last && mlen.size() > 0) model_pop();
    if (!space) m_full++;
    else if (bad_end) m_rej++;
    else if (n > DEPTH) m_over++;
    else if (malf_at >= 1 && malf_at <= n - 2) m_rej++;
    else if (proc_at < 1 || proc_at > n - 1) m_rej++;
    else begin
      foreach (fw[i]) mdata.push_back(fw[i]);
      mlen.push_back(n);
      mmask.push_back(last_mask);
    end
  endtask

  // Reads the whole head frame, checks it against the model, then discards it.
  task automatic read_head();
    int n, k;
    n = mlen[0];
    check("available", 64'(avail), 64'd1);
    check("counter", 64'(counter), 64'(n - 1));
    check("data_valid", 64'(dv), 64'(mmask[0]));
    k = 0;
    while (empty && k < 4) begin
      @(negedge clk);
      k++;
    end
    check("empty_clear", 64'(empty), 64'd0);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      check("rd_data", rd_data, mdata[i]);
      check("empty_track", 64'(empty), 64'(i == n - 1));
    end
    rd_discard = 1'b1;
    @(negedge clk);
    rd_discard = 1'b0;
    model_pop();
    check("empty_after_discard", 64'(empty), 64'd1);
  endtask

  task automatic drain();
    while (mlen.size() > 0) read_head();
    check("drained_avail", 64'(avail), 64'd0);
  endtask

  initial begin
    int n, pa, ma, r;
    logic [7:0] lm;
    bit be;
    logic [63:0] last_word;

    repeat (3) @(negedge clk);
    areset = 1'b0;
    check("rst_available", 64'(avail), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_counter", 64'(counter), 64'd0);
    check("rst_data_valid", 64'(dv), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    check_stats();

    // Three-word frame, process on word 2, last mask 0x0F.
    send_frame(3, 8'h0F, 1, 1'b0, -1, 1'b0);
    check("t1_available", 64'(avail), 64'd1);
    check("t1_empty_same_cycle", 64'(empty), 64'd0);
    check("t1_counter", 64'(counter), 64'd2);
    check("t1_data_valid", 64'(dv), 64'h0F);
    last_word = mdata[2];
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      check("t1_rd_data", rd_data, mdata[i]);
    end
    check("t1_empty_end", 64'(empty), 64'd1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("t1_rd_while_empty", rd_data, last_word);
    rd_discard = 1'b1;
    @(negedge clk);
    rd_discard = 1'b0;
    model_pop();
    check("t1_avail_after_discard", 64'(avail), 64'd0);

    // Ring full: fifth frame dropped, a discard makes room for the sixth.
    for (int i = 0; i < 5; i++) send_frame(4, 8'hFF, 2, 1'b0, -1, 1'b0);
    check("t2_model_ready", 64'(mlen.size()), 64'd4);
    check_stats();
    read_head();
    send_frame(5, 8'h01, 3, 1'b0, -1, 1'b0);
    check_stats();
    drain();

    // Overrun: one word past buffer depth.
    send_frame(DEPTH + 1, 8'hFF, 5, 1'b0, -1, 1'b0);
    check("t3_available", 64'(avail), 64'd0);
    check_stats();
    send_frame(DEPTH, 8'h7F, 9, 1'b0, -1, 1'b0);
    drain();

    // Bad frame, then good_frame without any process pulse.
    send_frame(2, 8'hFF, 1, 1'b1, -1, 1'b0);
    send_frame(4, 8'h3C, -1, 1'b0, -1, 1'b0);
    check("t4_available", 64'(avail), 64'd0);
    check_stats();

    // Commit of the next buffer in the same cycle the head is discarded.
    send_frame(3, 8'hFF, 1, 1'b0, -1, 1'b0);
    send_frame(4, 8'h03, 2, 1'b0, -1, 1'b1);
    check("t5_available", 64'(avail), 64'd1);
    check("t5_empty_hold", 64'(empty), 64'd1);
    @(negedge clk);
    check("t5_empty_clear", 64'(empty), 64'd0);
    drain();

    // Random frames interleaved with reads.
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3 && mlen.size() > 0) read_head();
      else begin
        n  = int'($urandom_range(2, 12));
        lm = 8'($urandom_range(1, 255));
        pa = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, n - 1));
        be = ($urandom_range(0, 9) == 0);
        ma = (n >= 3 && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, n - 2)) : -1;
        send_frame(n, lm, pa, be, ma, 1'b0);
        check("rnd_available", 64'(avail), 64'(mlen.size() > 0));
        check_stats();
      end
    end
    drain();

    // Reset in the middle of a frame with two frames pending.
    send_frame(3, 8'hFF, 1, 1'b0, -1, 1'b0);
    send_frame(3, 8'hFF, 1, 1'b0, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx_valid = 8'hFF;
      rx_data  = {$urandom, $urandom};
      proc     = (i == 1);
    end
    @(negedge clk);
    rx_valid = '0; proc = 1'b0;
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    while (mlen.size() > 0) model_pop();
    m_full = 0; m_over = 0; m_rej = 0;
    check("t6_available", 64'(avail), 64'd0);
    check("t6_empty", 64'(empty), 64'd1);
    check_stats();
    send_frame(3, 8'hF0, 2, 1'b0, -1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
